// File: rtl/output_stage_fifo_pkg.sv
// rtl/output_stage_fifo_pkg.sv - shared widths for PE array, output stage and fill controller
// Purpose: default accumulator/feature widths and rescale shift used across the slice.
// Ports: none (package).
package output_stage_fifo_pkg;

  localparam int ACC_W_DEF  = 32;
  localparam int DATA_W_DEF = 16;
  localparam int SHIFT_DEF  = 8;
  localparam int DEPTH_DEF  = 16;

endpackage

// File: rtl/output_stage_fifo_rescale.sv
// rtl/output_stage_fifo_rescale.sv - combinational shift, ReLU and saturation of one accumulator word
// Purpose: t = acc >>> SHIFT, optional clamp of negatives to 0, saturate to signed DATA_W.
// Ports:
//   acc_data  in  ACC_W   signed accumulator result
//   relu_en   in  1       clamp negative results to 0
//   res       out DATA_W  rescaled, saturated word
module sat_relu_rescale
  import output_stage_fifo_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic [ACC_W-1:0]  acc_data,
  input  logic              relu_en,
  output logic [DATA_W-1:0] res
);

  // Saturation bounds expressed at accumulator width; ~MAXV is the most negative value.
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

  logic signed [ACC_W-1:0] sh;
  logic signed [ACC_W-1:0] t;

  assign sh = $signed(acc_data) >>> SHIFT;

  always_comb begin
    t = sh;
    if (relu_en && (sh < 0)) begin
      t = '0;
    end
    if (t > MAXV) begin
      res = MAXV[DATA_W-1:0];
    end else if (t < MINV) begin
      res = MINV[DATA_W-1:0];
    end else begin
      res = t[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/output_stage_fifo.sv
// rtl/output_stage_fifo.sv - rescale stage plus show-ahead FIFO feeding the output-buffer fill controller
// Purpose: capture accepted accumulator words into a stage register (rescaled), then write
//   them into a DEPTH-entry register-array FIFO one edge later; show-ahead read port.
// Ports:
//   w_clk, reset (async, active-low), flush (sync clear, sticky flags kept)
//   relu_en, acc_valid, acc_data, acc_ready     accumulator input side
//   rd_en, rd_data, is_empty, is_full, count    fill-controller read side
//   overflow, underflow                         sticky error flags
module output_stage_fifo
  import output_stage_fifo_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic                     w_clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     relu_en,
  input  logic                     acc_valid,
  input  logic [ACC_W-1:0]         acc_data,
  output logic                     acc_ready,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     is_empty,
  output logic                     is_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              stage_valid;
  logic [DATA_W-1:0] stage_data;
  logic [DATA_W-1:0] rescaled;
  logic [PW:0]       occupancy;
  logic              accept;
  logic              push;
  logic              pop;

  sat_relu_rescale #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .SHIFT  (SHIFT)
  ) u_rescale (
    .acc_data (acc_data),
    .relu_en  (relu_en),
    .res      (rescaled)
  );

  // The stage word has a reserved slot, so acceptance counts it as already stored.
  assign occupancy = {1'b0, count} + {{PW{1'b0}}, stage_valid};
  assign acc_ready = occupancy < (PW+1)'(DEPTH);
  assign is_empty  = (count == '0);
  assign is_full   = (count == PW'(DEPTH));
  assign rd_data   = mem[rd_ptr[AW-1:0]];

  assign accept = acc_valid & acc_ready & ~flush;
  assign push   = stage_valid & ~flush;
  assign pop    = rd_en & ~is_empty & ~flush;

  always_ff @(posedge w_clk or negedge reset) begin
    if (!reset) begin
      stage_valid <= 1'b0;
      stage_data  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else if (flush) begin
      stage_valid <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      stage_valid <= accept;
      if (accept) begin
        stage_data <= rescaled;
      end
      if (acc_valid && !acc_ready) begin
        overflow <= 1'b1;
      end
      if (rd_en && is_empty) begin
        underflow <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset so it maps onto distributed RAM.
  always_ff @(posedge w_clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= stage_data;
    end
  end

endmodule

// File: tb/tb_output_stage_fifo.sv
// tb/tb_output_stage_fifo.sv - scoreboard bench for output_stage_fifo
module tb_output_stage_fifo;

  logic        w_clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        relu_en = 1'b0;
  logic        acc_valid = 1'b0;
  logic [31:0] acc_data = '0;
  logic        acc_ready;
  logic        rd_en = 1'b0;
  logic [15:0] rd_data;
  logic        is_empty;
  logic        is_full;
  logic [4:0]  count;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic        m_stage_valid = 1'b0;
  logic [15:0] m_stage_val = '0;
  logic        m_ovf = 1'b0;
  logic        m_udf = 1'b0;

  output_stage_fifo #(.ACC_W(32), .DATA_W(16), .DEPTH(16), .SHIFT(8)) dut (
    .w_clk     (w_clk),
    .reset     (reset),
    .flush     (flush),
    .relu_en   (relu_en),
    .acc_valid (acc_valid),
    .acc_data  (acc_data),
    .acc_ready (acc_ready),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .is_empty  (is_empty),
    .is_full   (is_full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 w_clk = ~w_clk;

  function automatic logic [15:0] ref_rescale(input logic [31:0] a, input logic r);
    longint t;
    logic [63:0] tv;
    t = longint'($signed(a));
    t = t / 256;
    if (t * 256 != longint'($signed(a)) && longint'($signed(a)) < 0) t = t - 1;
    if (r && t < 0) t = 0;
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    tv = t;
    return tv[15:0];
  endfunction

  function automatic void model_clear(input logic clr_flags);
    exp_q.delete();
    m_stage_valid = 1'b0;
    if (clr_flags) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
  endfunction

  // One clock cycle: drive, check ready/popped data against the model, advance model.
  task automatic cycle(input logic av, input logic [31:0] ad, input logic rl,
                       input logic re, input logic fl);
    logic m_ready;
    logic acc;
    acc_valid = av; acc_data = ad; relu_en = rl; rd_en = re; flush = fl;
    #2;
    m_ready = (exp_q.size() + int'(m_stage_valid)) < 16;
    checks++;
    if (acc_ready !== m_ready) begin
      failures++;
      $display("FAIL acc_ready: got %b expected %b", acc_ready, m_ready);
    end
    acc = av & m_ready & ~fl;
    if (!fl) begin
      if (av && !m_ready) m_ovf = 1'b1;
      if (re && exp_q.size() == 0) m_udf = 1'b1;
      if (re && exp_q.size() > 0) begin
        checks++;
        if (rd_data !== exp_q[0]) begin
          failures++;
          $display("FAIL pop_data: got %h expected %h", rd_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      if (m_stage_valid) exp_q.push_back(m_stage_val);
      m_stage_valid = acc;
      if (acc) m_stage_val = ref_rescale(ad, rl);
    end else begin
      model_clear(1'b0);
    end
    @(posedge w_clk);
    #1;
    acc_valid = 1'b0; rd_en = 1'b0; flush = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (exp_q.size() > 0 || m_stage_valid); i++)
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++;
    if (count !== 5'd0 || is_empty !== 1'b1 || is_full !== 1'b0 || overflow !== 1'b0 ||
        underflow !== 1'b0 || acc_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_values: count=%0d empty=%b full=%b ovf=%b udf=%b ready=%b expected 0 1 0 0 0 1",
               count, is_empty, is_full, overflow, underflow, acc_ready);
    end
    reset = 1'b1;
    @(posedge w_clk);
    #1;
    model_clear(1'b1);
  endtask

  task automatic test_single_word();
    cycle(1'b1, 32'h00012345, 1'b0, 1'b0, 1'b0);
    checks++;
    if (is_empty !== 1'b1) begin
      failures++;
      $display("FAIL single_latency_e0: is_empty=%b expected 1", is_empty);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (is_empty !== 1'b0 || rd_data !== 16'h0123 || count !== 5'd1) begin
      failures++;
      $display("FAIL single_word: empty=%b data=%h count=%0d expected 0 0123 1", is_empty, rd_data, count);
    end
    drain();
  endtask

  task automatic test_saturation_relu();
    logic [31:0] a [4] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFF00, 32'hFFFFFF00};
    logic        r [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] e [4] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};
    for (int i = 0; i < 4; i++) cycle(1'b1, a[i], r[i], 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data !== e[i]) begin
        failures++;
        $display("FAIL sat_relu[%0d]: got %h expected %h", i, rd_data, e[i]);
      end
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_fill_overflow();
    int acc_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (acc_ready) acc_cnt++;
      cycle(1'b1, 32'h100 * (i + 1), 1'b0, 1'b0, 1'b0);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (acc_cnt != 16 || count !== 5'd16 || is_full !== 1'b1 || overflow !== 1'b1 || acc_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_overflow: accepted=%0d count=%0d full=%b ovf=%b ready=%b expected 16 16 1 1 0",
               acc_cnt, count, is_full, overflow, acc_ready);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) cycle(1'b1, 32'h1000 + i * 256, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 32'h20000 + i * 256, 1'b0, 1'b1, 1'b0);
      checks++;
      if (count > 5'd16 || count !== 5'(exp_q.size())) begin
        failures++;
        $display("FAIL full_pushpop_count: got %0d expected %0d", count, exp_q.size());
      end
    end
    drain();
    for (int i = 0; i < 200; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if (count !== 5'(exp_q.size())) begin
        failures++;
        $display("FAIL random_count: got %0d expected %0d", count, exp_q.size());
      end
    end
    drain();
    checks++;
    if (is_empty !== 1'b1 || count !== 5'd0) begin
      failures++;
      $display("FAIL random_drain: empty=%b count=%0d expected 1 0", is_empty, count);
    end
  endtask

  task automatic test_underflow_flush();
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (underflow !== 1'b1 || count !== 5'd0) begin
      failures++;
      $display("FAIL underflow: udf=%b count=%0d expected 1 0", underflow, count);
    end
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h300 + i * 256, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd5) begin
      failures++;
      $display("FAIL flush_prefill: count=%0d expected 5", count);
    end
    cycle(1'b1, 32'h12345, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd0 || is_empty !== 1'b1 || underflow !== 1'b1 || overflow !== m_ovf) begin
      failures++;
      $display("FAIL flush: count=%0d empty=%b udf=%b ovf=%b expected 0 1 1 %b",
               count, is_empty, underflow, overflow, m_ovf);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'h4400 + i * 256, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd7) begin
      failures++;
      $display("FAIL pre_reset_count: got %0d expected 7", count);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (count !== 5'd0 || is_empty !== 1'b1 || is_full !== 1'b0 || overflow !== 1'b0 ||
        underflow !== 1'b0 || acc_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: count=%0d empty=%b full=%b ovf=%b udf=%b ready=%b expected 0 1 0 0 0 1",
               count, is_empty, is_full, overflow, underflow, acc_ready);
    end
    model_clear(1'b1);
    @(posedge w_clk);
    #2;
    reset = 1'b1;
    @(posedge w_clk);
    #1;
    checks++;
    if (count !== 5'd0) begin
      failures++;
      $display("FAIL post_reset_count: got %0d expected 0", count);
    end
    cycle(1'b1, 32'h0000AB00, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (rd_data !== 16'h00AB || count !== 5'd1) begin
      failures++;
      $display("FAIL post_reset_word: data=%h count=%0d expected 00ab 1", rd_data, count);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_saturation_relu();
    test_fill_overflow();
    test_back_to_back();
    test_underflow_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
